// File: rtl/id_scoreboard_ctrl.sv
// id_scoreboard_ctrl
// Issue controller for the ID stage of a 5-stage pipeline. It keeps a 3-slot
// shadow of in-flight register writes (ID/EX, EX/MEM, MEM/WB), stalls the
// front end on read-after-write hazards and redirects on taken control
// transfers. It also counts stall cycles and flags stall deadlock.
//
// Parameters
//   WB_BYPASS    1: register file is write-through, so the WB slot never stalls
//   MAX_STALL    consecutive stall cycles that set the sticky hang flag
// Ports
//   Clk, Rst                 clock, synchronous active-high reset
//   IF_ID_Valid              IF/ID holds a real instruction
//   IF_ID_Rs/Rt, UsesRs/Rt   source registers and their read enables
//   IF_ID_Rd, IF_ID_RegWrite destination register and its write enable
//   branch, jump, jumpReg    taken control transfer resolved in ID
//   PCWrite, IF_ID_Write     front-end load enables (combinational)
//   control                  1 passes decode to ID/EX, 0 inserts a bubble
//   IF_ID_flush              zero IF/ID at the next edge
//   busy_mask                per-register pending flags, bit 0 always 0
//   stall_count              saturating total of stall cycles
//   hang                     sticky deadlock flag
module id_scoreboard_ctrl #(
    parameter bit          WB_BYPASS = 1'b0,
    parameter int unsigned MAX_STALL = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        IF_ID_Valid,
    input  logic [4:0]  IF_ID_Rs,
    input  logic [4:0]  IF_ID_Rt,
    input  logic        IF_ID_UsesRs,
    input  logic        IF_ID_UsesRt,
    input  logic [4:0]  IF_ID_Rd,
    input  logic        IF_ID_RegWrite,
    input  logic        branch,
    input  logic        jump,
    input  logic        jumpReg,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        control,
    output logic        IF_ID_flush,
    output logic [31:0] busy_mask,
    output logic [15:0] stall_count,
    output logic        hang
);

    localparam int unsigned RegW   = 5;
    localparam int unsigned NumReg = 32;
    localparam int unsigned CntW   = 16;
    localparam int unsigned RunW   = 8;

    typedef struct packed {
        logic            v;
        logic [RegW-1:0] rd;
    } slot_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    slot_t               ex_q, mem_q, wb_q;
    slot_t               ex_d;
    logic [CntW-1:0]     stall_cnt_q, stall_cnt_d;
    logic [RunW-1:0]     run_cnt_q, run_cnt_d;
    logic                hang_q, hang_d;

    logic [NumReg-1:0]   pend_mask;
    logic                valid_eff;
    logic                raw;
    logic                issue;
    logic                ctl;

    // Pending-write mask; register 0 is never pending.
    always_comb begin
        pend_mask = '0;
        for (int unsigned r = 1; r < NumReg; r++) begin
            pend_mask[r] = (ex_q.v  && (ex_q.rd  == RegW'(r))) ||
                           (mem_q.v && (mem_q.rd == RegW'(r))) ||
                           (!WB_BYPASS && wb_q.v && (wb_q.rd == RegW'(r)));
        end
    end

    assign busy_mask = pend_mask;

    // Hazard detection; jumpReg always reads Rs to obtain its target.
    always_comb begin
        valid_eff = IF_ID_Valid && (state_q != ST_REDIRECT);
        raw       = valid_eff &&
                    (((IF_ID_UsesRs || jumpReg) && pend_mask[IF_ID_Rs]) ||
                     (IF_ID_UsesRt && pend_mask[IF_ID_Rt]));
        issue     = valid_eff && !raw;
        ctl       = issue && (branch || jump || jumpReg);
    end

    // Next state and front-end control.
    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        control     = 1'b0;
        IF_ID_flush = 1'b0;

        case (state_q)
            ST_RUN, ST_STALL: begin
                if (raw) begin
                    state_d = ST_STALL;
                end else if (ctl) begin
                    state_d = ST_REDIRECT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_REDIRECT: state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase

        if (raw) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            control     = 1'b0;
            IF_ID_flush = 1'b0;
        end else if (ctl) begin
            PCWrite     = 1'b1;
            IF_ID_Write = 1'b0;
            control     = 1'b1;
            IF_ID_flush = 1'b1;
        end else if (issue) begin
            PCWrite     = 1'b1;
            IF_ID_Write = 1'b1;
            control     = 1'b1;
            IF_ID_flush = 1'b0;
        end

        // Hold the front end and clear IF/ID while reset is asserted.
        if (Rst) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            control     = 1'b0;
            IF_ID_flush = 1'b1;
        end
    end

    // Shadow-pipeline insertion; writes to r0 never occupy a slot.
    always_comb begin
        ex_d.v  = issue && IF_ID_RegWrite && (IF_ID_Rd != '0);
        ex_d.rd = IF_ID_Rd;
    end

    // Stall statistics and deadlock detection.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        run_cnt_d   = '0;
        hang_d      = hang_q;
        if (raw) begin
            if (stall_cnt_q != {CntW{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CntW'(1);
            end
            run_cnt_d = (run_cnt_q == {RunW{1'b1}}) ? run_cnt_q : run_cnt_q + RunW'(1);
            if ((32'(run_cnt_q) + 32'd1) >= 32'(MAX_STALL)) begin
                hang_d = 1'b1;
            end
        end
    end

    // State, slot and counter registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= ST_RUN;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            run_cnt_q   <= '0;
            hang_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_q        <= mem_q;
            mem_q       <= ex_q;
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            run_cnt_q   <= run_cnt_d;
            hang_q      <= hang_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign hang        = hang_q;

endmodule
